// File: rtl/effect_pkg.sv
// Shared types for the echo effect: sample type, FSM states and the 17->16 bit saturator.
package effect_pkg;

   typedef logic signed [15:0] sample_t;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_CALC, S_WR} delay_state_e;

   // The top two bits disagree only when the 17-bit sum left the 16-bit range.
   function automatic sample_t sat16(input logic signed [16:0] v);
      if (v[16] != v[15])
         return v[16] ? 16'sh8000 : 16'sh7FFF;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port sample buffer, synchronous read with 1-cycle latency, read-before-write.
// No reset so it maps onto block RAM; contents are undefined until written.
module delay_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              i_clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      rdata <= mem[addr];
      if (we)
         mem[addr] <= wdata;
   end

endmodule

// File: rtl/effect_delay.sv
// Feedback echo: i_valid -> o_valid 3 cycles later, one sample per 4 cycles.
// No backpressure; an i_valid arriving while busy is dropped and flagged on o_overrun.
module effect_delay
   import effect_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int MIX_SHIFT = 1,
   parameter int FB_SHIFT  = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic               i_enable,
   input  logic [2:0]         i_level,
   input  logic signed [15:0] i_data,
   output logic signed [15:0] o_data,
   output logic               o_valid,
   output logic               o_overrun
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   delay_state_e      state;
   logic [ADDR_W-1:0] wr_ptr, rd_addr, rd_ptr, ram_addr;
   logic [ADDR_W:0]   fill_cnt, d_len, in_len;
   sample_t           x_r, wval, ram_q, d_val;
   logic              en_r, ram_we;
   logic signed [16:0] x_ext, d_ext, mix_sum, fb_sum;

   // Delay length from the live level input; D == DEPTH wraps rd_ptr onto wr_ptr.
   always_comb begin
      in_len = ({{(ADDR_W-2){1'b0}}, i_level} + LEN_ONE) << (ADDR_W-3);
      rd_ptr = wr_ptr - in_len[ADDR_W-1:0];
   end

   always_comb begin
      ram_addr = rd_addr;
      if (state == S_IDLE)
         ram_addr = rd_ptr;
      else if (state == S_WR)
         ram_addr = wr_ptr;
   end

   assign ram_we    = (state == S_WR) && !i_rst;
   assign o_overrun = i_valid && (state != S_IDLE);

   delay_ram #(.DATA_W(16), .ADDR_W(ADDR_W)) u_ram (
      .i_clk (i_clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wval),
      .rdata (ram_q)
   );

   // Until D samples have been written since reset the delayed tap is treated as silence.
   always_comb begin
      d_val   = (fill_cnt < d_len) ? '0 : ram_q;
      x_ext   = {x_r[15], x_r};
      d_ext   = {d_val[15], d_val};
      mix_sum = x_ext + (d_ext >>> MIX_SHIFT);
      fb_sum  = x_ext + (d_ext >>> FB_SHIFT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_IDLE;
         wr_ptr   <= '0;
         fill_cnt <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  x_r     <= i_data;
                  en_r    <= i_enable;
                  d_len   <= in_len;
                  rd_addr <= rd_ptr;
                  state   <= S_RD;
               end
            end
            S_RD: state <= S_CALC;
            S_CALC: begin
               o_data  <= en_r ? sat16(mix_sum) : x_r;
               wval    <= en_r ? sat16(fb_sum)  : x_r;
               o_valid <= 1'b1;
               state   <= S_WR;
            end
            S_WR: begin
               wr_ptr <= wr_ptr + PTR_ONE;
               if (fill_cnt != FILL_MAX)
                  fill_cnt <= fill_cnt + LEN_ONE;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_effect_delay.sv
// Bench for effect_delay at ADDR_W=4 (DEPTH=16, D=2*(level+1)): queue model plus directed literals.
module tb_effect_delay;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_valid = 1'b0;
   logic               i_enable = 1'b0;
   logic [2:0]         i_level = 3'd0;
   logic signed [15:0] i_data = 16'sd0;
   logic signed [15:0] o_data;
   logic               o_valid, o_overrun;

   effect_delay #(.ADDR_W(4), .MIX_SHIFT(1), .FB_SHIFT(1)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .i_enable  (i_enable),
      .i_level   (i_level),
      .i_data    (i_data),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_overrun (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Behavioural model: buffer as an int array, results scheduled 3 cycles after acceptance.
   typedef struct { int cyc; int val; int w; } pend_t;
   pend_t pq[$];
   pend_t pe;
   int  mbuf [16];
   int  mwr = 0, mfill = 0, busy_until = -100, exp_hold = 0;
   bit  live = 0;
   bit  exp_v;
   int  md, mrd, mdv, mx, mo;

   always @(negedge i_clk) begin
      exp_v = 1'b0;
      if (live) begin
         if (pq.size() > 0 && pq[0].cyc == cyc) begin
            exp_v    = 1'b1;
            exp_hold = pq[0].val;
         end
         chk("o_valid", int'(o_valid), int'(exp_v));
         chk("o_data", int'(o_data), exp_hold);
         chk("o_overrun", int'(o_overrun), int'(i_valid && cyc <= busy_until));
         if (exp_v) begin
            if (!i_rst) begin
               mbuf[mwr] = pq[0].w;
               mwr = (mwr + 1) % 16;
               if (mfill < 16) mfill++;
            end
            void'(pq.pop_front());
         end
      end
      if (i_rst) begin
         live = 1'b1;
         pq.delete();
         mwr = 0;
         mfill = 0;
         exp_hold = 0;
         busy_until = cyc;
      end else if (live && i_valid && cyc > busy_until) begin
         md  = 2 * (int'(i_level) + 1);
         mrd = (mwr - md + 32) % 16;
         mdv = (mfill < md) ? 0 : mbuf[mrd];
         mx  = int'(i_data);
         mo  = i_enable ? sat(mx + (mdv >>> 1)) : mx;
         pe.cyc = cyc + 3;
         pe.val = mo;
         pe.w   = mo;
         pq.push_back(pe);
         busy_until = cyc + 3;
      end
   end

   // One sample per 8 cycles; reports the value and the cycle offset of its o_valid.
   task automatic send(input int x, input bit en, input int lvl, output int got, output int voff);
      got  = 99999;
      voff = -1;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk); #1;
         i_valid = (k == 0);
         if (k == 0) begin
            i_data   = 16'(x);
            i_enable = en;
            i_level  = 3'(lvl);
         end
         @(negedge i_clk);
         if (o_valid) begin
            got  = int'(o_data);
            voff = k;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   int got, voff, vcnt, vpos, ocnt, opos;
   int exp1 [8] = '{1000, 0, 500, 0, 250, 0, 125, 0};

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_o_data", int'(o_data), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_o_overrun", int'(o_overrun), 0);

      // Impulse through the shortest delay
      for (int s = 0; s < 8; s++) begin
         send((s == 0) ? 1000 : 0, 1'b1, 0, got, voff);
         chk($sformatf("impulse_s%0d", s), got, exp1[s]);
      end

      // Bypass passes dry input and still records it
      send(-1234, 1'b0, 0, got, voff);
      chk("bypass_data", got, -1234);
      chk("bypass_latency", voff, 3);
      send(0, 1'b1, 0, got, voff);
      chk("bypass_echo_s1", got, 0);
      send(0, 1'b1, 0, got, voff);
      chk("bypass_echo_s2", got, -617);

      // Saturation both polarities
      do_reset();
      for (int s = 0; s < 6; s++) begin
         send(30000, 1'b1, 0, got, voff);
         chk($sformatf("sat_pos_s%0d", s), got, (s < 2) ? 30000 : 32767);
      end
      do_reset();
      for (int s = 0; s < 6; s++) begin
         send(-30000, 1'b1, 0, got, voff);
         chk($sformatf("sat_neg_s%0d", s), got, (s < 2) ? -30000 : -32768);
      end

      // Fill gating: stale full-scale RAM must stay invisible at the longest delay
      do_reset();
      for (int s = 0; s < 16; s++) send(32767, 1'b1, 0, got, voff);
      do_reset();
      for (int s = 0; s < 17; s++) begin
         send(0, 1'b1, 7, got, voff);
         chk($sformatf("fill_s%0d", s), got, 0);
      end

      // Overrun: second strobe two cycles after the first is dropped
      vcnt = 0; vpos = -1; ocnt = 0; opos = -1;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk); #1;
         i_valid  = (k == 0 || k == 2);
         i_data   = (k == 2) ? 16'sd5000 : 16'sd100;
         i_enable = 1'b1;
         i_level  = 3'd0;
         @(negedge i_clk);
         if (o_valid) begin vcnt++; vpos = k; got = int'(o_data); end
         if (o_overrun) begin ocnt++; opos = k; end
      end
      chk("ovr_valid_count", vcnt, 1);
      chk("ovr_valid_pos", vpos, 3);
      chk("ovr_data", got, 100);
      chk("ovr_pulse_count", ocnt, 1);
      chk("ovr_pulse_pos", opos, 2);

      // Reset while the sample sits in the calc stage
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk); #1;
         i_valid  = (k == 0);
         i_data   = 16'sd777;
         i_enable = 1'b1;
         i_level  = 3'd0;
         i_rst    = (k == 2);
         @(negedge i_clk);
         if (o_valid) vcnt++;
      end
      chk("midrst_valid_count", vcnt, 0);
      chk("midrst_o_data", int'(o_data), 0);
      for (int s = 0; s < 8; s++) begin
         send((s == 0) ? 1000 : 0, 1'b1, 0, got, voff);
         chk($sformatf("post_rst_impulse_s%0d", s), got, exp1[s]);
      end

      repeat (4) @(posedge i_clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
